// File: rtl/cache_controller_if.sv
// CPU, data-RAM and backing-memory signals of the cache controller, bundled.
// The controller takes the slave view; the requester and memories take the master view.
interface cache_controller_if #(
  parameter int ADDR_LENGTH  = 32,
  parameter int INDEX_LENGTH = 4,
  parameter int DATA_LENGTH  = 32,
  parameter int CNT_WIDTH    = 16
);
  logic                    cpu_req_i;
  logic                    cpu_we_i;
  logic [ADDR_LENGTH-1:0]  cpu_addr_i;
  logic [DATA_LENGTH-1:0]  cpu_wdata_i;
  logic [DATA_LENGTH-1:0]  cpu_rdata_o;
  logic                    cpu_ack_o;
  logic [INDEX_LENGTH-1:0] ram_index_o;
  logic [DATA_LENGTH-1:0]  ram_data_o;
  logic                    ram_we_o;
  logic [DATA_LENGTH-1:0]  ram_data_i;
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [ADDR_LENGTH-1:0]  mem_addr_o;
  logic [DATA_LENGTH-1:0]  mem_wdata_o;
  logic [DATA_LENGTH-1:0]  mem_rdata_i;
  logic                    mem_ack_i;
  logic [CNT_WIDTH-1:0]    hit_cnt_o;
  logic [CNT_WIDTH-1:0]    miss_cnt_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, ram_data_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_ack_o, ram_index_o, ram_data_o, ram_we_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, hit_cnt_o, miss_cnt_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, ram_data_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_ack_o, ram_index_o, ram_data_o, ram_we_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate cache sequencer.
// Tags/valids live here; line data sits in an external combinational-read RAM.
module cache_controller #(
  parameter int ADDR_LENGTH  = 32,
  parameter int INDEX_LENGTH = 4,
  parameter int DATA_LENGTH  = 32,
  parameter int CNT_WIDTH    = 16
) (
  input logic clk,
  input logic rst,
  cache_controller_if.slave bus
);
  localparam int TAG_LENGTH = ADDR_LENGTH - INDEX_LENGTH;
  localparam int LINES      = 1 << INDEX_LENGTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, FILL, UPDATE, MEM_WR, RESP} state_t;

  state_t state, next;

  logic [ADDR_LENGTH-1:0]             addr_q;
  logic                               we_q;
  logic [DATA_LENGTH-1:0]             wdata_q, rdata_q;
  logic [LINES-1:0]                   valid;
  logic [LINES-1:0][TAG_LENGTH-1:0]   tags;
  logic [CNT_WIDTH-1:0]               hit_cnt, miss_cnt;

  logic [INDEX_LENGTH-1:0] idx;
  logic [TAG_LENGTH-1:0]   tag;
  logic                    hit;

  assign idx = addr_q[INDEX_LENGTH-1:0];
  assign tag = addr_q[ADDR_LENGTH-1:INDEX_LENGTH];
  assign hit = valid[idx] && (tags[idx] == tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (bus.cpu_req_i) next = LOOKUP;
      LOOKUP:  begin
        if (we_q) next = hit ? UPDATE : MEM_WR;
        else      next = hit ? RESP   : MEM_RD;
      end
      MEM_RD:  if (bus.mem_ack_i) next = FILL;
      FILL:    next = RESP;
      UPDATE:  next = MEM_WR;
      MEM_WR:  if (bus.mem_ack_i) next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      valid    <= '0;
      tags     <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == IDLE && bus.cpu_req_i) begin
        addr_q  <= bus.cpu_addr_i;
        we_q    <= bus.cpu_we_i;
        wdata_q <= bus.cpu_wdata_i;
      end
      if (state == LOOKUP) begin
        if (hit) begin
          if (!we_q) rdata_q <= bus.ram_data_i;
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_ONE;
        end else if (miss_cnt != '1) begin
          miss_cnt <= miss_cnt + CNT_ONE;
        end
      end
      if (state == MEM_RD && bus.mem_ack_i) rdata_q <= bus.mem_rdata_i;
      // Tag/valid only change on a read fill; write misses never allocate.
      if (state == FILL) begin
        tags[idx]  <= tag;
        valid[idx] <= 1'b1;
      end
    end
  end

  // All outputs decode from registered state so reset clears them immediately.
  always_comb begin
    bus.cpu_rdata_o = rdata_q;
    bus.cpu_ack_o   = (state == RESP);
    bus.ram_index_o = idx;
    bus.ram_data_o  = '0;
    bus.ram_we_o    = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.hit_cnt_o   = hit_cnt;
    bus.miss_cnt_o  = miss_cnt;
    unique case (state)
      FILL: begin
        bus.ram_we_o   = 1'b1;
        bus.ram_data_o = rdata_q;
      end
      UPDATE: begin
        bus.ram_we_o   = 1'b1;
        bus.ram_data_o = wdata_q;
      end
      MEM_RD: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = addr_q;
      end
      MEM_WR: begin
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = addr_q;
        bus.mem_wdata_o = wdata_q;
      end
      default: ;
    endcase
  end
endmodule
